lcd_timing: RTL and testbench

Dot/line timing generator for the LCD pipeline. It counts dots and lines for the 456-dot × 154-line frame and derives the LCD mode and LY. It emits the per-line `drawline` strobe consumed by the line renderer, plus the LY=LYC coincidence flag and the VBlank/STAT interrupt pulses. It sits between the LCDC/STAT register file (inputs) and the renderer and interrupt controller (outputs).

---
 rtl/lcd_timing.sv | 153 +++++++++++++++
 tb/tb_lcd_timing.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing.sv
`default_nettype none
// ============================================================================
// Module   : lcd_timing
// Brief    : Dot/line timing generator: LY, dot counter, LCD mode, drawline,
//            LY=LYC coincidence, VBlank and STAT interrupt pulses.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_timing #(
    parameter int DOTS_PER_LINE = 456,
    parameter int OAM_DOTS      = 80,
    parameter int XFER_DOTS     = 172,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dot_en,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_ie,
    output logic [7:0] ly,
    output logic [8:0] dot_x,
    output logic [1:0] mode,
    output logic       coincidence,
    output logic       drawline,
    output logic       frame_start,
    output logic       vblank_irq,
    output logic       stat_irq
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    localparam logic [1:0] c_mode_hblank = 2'd0;
    localparam logic [1:0] c_mode_vblank = 2'd1;
    localparam logic [1:0] c_mode_oam    = 2'd2;
    localparam logic [1:0] c_mode_xfer   = 2'd3;

    localparam logic [8:0] c_last_dot  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] c_oam_end   = 9'(OAM_DOTS);
    localparam logic [8:0] c_xfer_end  = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] c_last_line = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] c_vis_lines = 8'(VISIBLE_LINES);

    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic       r_stat_line_q;

    logic [8:0] w_dot_next;
    logic [7:0] w_ly_next;
    logic [1:0] w_mode_next;
    logic       w_adv;
    logic       w_wrap;
    logic       w_drawline_next;
    logic       w_vblank_next;
    logic       w_frame_next;
    logic       w_stat_line;

    // Idle means "was disabled at the previous edge"; the next enabled edge is the load edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!lcd_enable) begin
            w_state_next = c_st_idle;
        end else begin
            w_state_next = c_st_run;
        end
    end

    always_comb begin
        w_dot_next = dot_x;
        w_ly_next  = ly;
        w_adv      = 1'b0;
        w_wrap     = 1'b0;
        if (r_state == c_st_idle) begin
            w_dot_next = '0;
            w_ly_next  = '0;
        end else if (dot_en) begin
            w_adv = 1'b1;
            if (dot_x == c_last_dot) begin
                w_dot_next = '0;
                w_wrap     = 1'b1;
                w_ly_next  = (ly == c_last_line) ? 8'd0 : ly + 8'd1;
            end else begin
                w_dot_next = dot_x + 9'd1;
            end
        end

        if (w_ly_next >= c_vis_lines) begin
            w_mode_next = c_mode_vblank;
        end else if (w_dot_next < c_oam_end) begin
            w_mode_next = c_mode_oam;
        end else if (w_dot_next < c_xfer_end) begin
            w_mode_next = c_mode_xfer;
        end else begin
            w_mode_next = c_mode_hblank;
        end

        w_drawline_next = w_adv && (w_dot_next == c_oam_end) && (w_ly_next < c_vis_lines);
        w_vblank_next   = w_wrap && (w_ly_next == c_vis_lines);
        w_frame_next    = (r_state == c_st_idle) || (w_wrap && (w_ly_next == 8'd0));

        // The STAT line is held low on the load edge so enabling never raises a stale request.
        w_stat_line = (r_state == c_st_run) &&
                      ((stat_ie[0] && (mode == c_mode_hblank)) ||
                       (stat_ie[1] && (mode == c_mode_vblank)) ||
                       (stat_ie[2] && (mode == c_mode_oam))    ||
                       (stat_ie[3] && coincidence));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dot_x         <= '0;
            ly            <= '0;
            mode          <= c_mode_hblank;
            coincidence   <= 1'b0;
            drawline      <= 1'b0;
            frame_start   <= 1'b0;
            vblank_irq    <= 1'b0;
            stat_irq      <= 1'b0;
            r_stat_line_q <= 1'b0;
        end else if (!lcd_enable) begin
            dot_x         <= '0;
            ly            <= '0;
            mode          <= c_mode_hblank;
            coincidence   <= 1'b0;
            drawline      <= 1'b0;
            frame_start   <= 1'b0;
            vblank_irq    <= 1'b0;
            stat_irq      <= 1'b0;
            r_stat_line_q <= 1'b0;
        end else begin
            dot_x         <= w_dot_next;
            ly            <= w_ly_next;
            mode          <= w_mode_next;
            coincidence   <= (w_ly_next == lyc);
            drawline      <= w_drawline_next;
            frame_start   <= w_frame_next;
            vblank_irq    <= w_vblank_next;
            stat_irq      <= w_stat_line && !r_stat_line_q;
            r_stat_line_q <= w_stat_line;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_timing
// Brief    : Self-checking bench for lcd_timing against a frame-position model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_timing;

    localparam int DPL   = 456;
    localparam int LINES = 154;
    localparam int FRAME = DPL * LINES;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       dot_en = 1'b1;
    logic       lcd_enable = 1'b1;
    logic [7:0] lyc = 8'd10;
    logic [3:0] stat_ie = 4'b1001;
    logic [7:0] ly;
    logic [8:0] dot_x;
    logic [1:0] mode;
    logic       coincidence, drawline, frame_start, vblank_irq, stat_irq;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    lcd_timing dut (
        .clk(clk), .reset_n(reset_n), .dot_en(dot_en), .lcd_enable(lcd_enable),
        .lyc(lyc), .stat_ie(stat_ie), .ly(ly), .dot_x(dot_x), .mode(mode),
        .coincidence(coincidence), .drawline(drawline), .frame_start(frame_start),
        .vblank_irq(vblank_irq), .stat_irq(stat_irq)
    );

    always #5 clk = ~clk;

    // Model: the whole frame is one dot index p in 0..FRAME-1.
    function automatic logic [1:0] mode_of(int p);
        int l, x;
        l = p / DPL;
        x = p % DPL;
        if (l >= 144) return 2'd1;
        if (x < 80) return 2'd2;
        if (x < 252) return 2'd3;
        return 2'd0;
    endfunction

    int         m_pos = 0;
    bit         m_run = 1'b0;
    bit         m_lq = 1'b0;
    logic [7:0] e_ly = '0;
    logic [8:0] e_dx = '0;
    logic [1:0] e_mode = '0;
    logic       e_coin = 0, e_dl = 0, e_fs = 0, e_vb = 0, e_irq = 0;

    always @(posedge clk or negedge reset_n) begin : model
        int p;
        bit adv, line;
        if (!reset_n || !lcd_enable) begin
            m_pos <= 0; m_run <= 1'b0; m_lq <= 1'b0;
            e_ly <= '0; e_dx <= '0; e_mode <= '0;
            e_coin <= 1'b0; e_dl <= 1'b0; e_fs <= 1'b0; e_vb <= 1'b0; e_irq <= 1'b0;
        end else begin
            line = m_run && ((stat_ie[0] && e_mode == 2'd0) || (stat_ie[1] && e_mode == 2'd1) ||
                             (stat_ie[2] && e_mode == 2'd2) || (stat_ie[3] && e_coin));
            adv = m_run && dot_en;
            p = !m_run ? 0 : (adv ? (m_pos + 1) % FRAME : m_pos);
            m_pos  <= p;
            m_run  <= 1'b1;
            m_lq   <= line;
            e_irq  <= line && !m_lq;
            e_dx   <= 9'(p % DPL);
            e_ly   <= 8'(p / DPL);
            e_mode <= mode_of(p);
            e_coin <= ((p / DPL) == int'(lyc));
            e_dl   <= adv && (p % DPL == 80) && (p / DPL < 144);
            e_vb   <= adv && (p == 144 * DPL);
            e_fs   <= !m_run || (adv && p == 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ({ly, dot_x, mode, coincidence, drawline, frame_start, vblank_irq, stat_irq} !==
                {e_ly, e_dx, e_mode, e_coin, e_dl, e_fs, e_vb, e_irq}) begin
                n_err++;
                $display("FAIL model t=%0t got ly=%0d x=%0d m=%0d c=%0b dl=%0b fs=%0b vb=%0b irq=%0b exp ly=%0d x=%0d m=%0d c=%0b dl=%0b fs=%0b vb=%0b irq=%0b",
                         $time, ly, dot_x, mode, coincidence, drawline, frame_start, vblank_irq, stat_irq,
                         e_ly, e_dx, e_mode, e_coin, e_dl, e_fs, e_vb, e_irq);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int dl_first, dl_last, dl_cnt, dl_gap_bad, vb_cnt, vb_k, vb_ly, fs_cnt, fs_k, irq_win;
        int cnt, found, nz;
        dl_first = -1; dl_last = 0; dl_cnt = 0; dl_gap_bad = 0;
        vb_cnt = 0; vb_k = -1; vb_ly = -1; fs_cnt = 0; fs_k = -1; irq_win = 0;

        // Reset held for 3 clocks with the LCD enabled.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_ly", int'(ly), 0);
        chk("reset_dot_x", int'(dot_x), 0);
        chk("reset_mode", int'(mode), 0);
        chk("reset_pulses", int'({drawline, frame_start, vblank_irq, stat_irq}), 0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("enable_frame_start", int'(frame_start), 1);
        chk("enable_mode", int'(mode), 2);

        // Full frame with dot_en high; lyc=10 and ie=1001 exercise STAT blocking.
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (drawline) begin
                if (dl_cnt == 0) dl_first = k;
                else if (k - dl_last != DPL) dl_gap_bad++;
                dl_last = k;
                dl_cnt++;
            end
            if (vblank_irq) begin vb_cnt++; vb_k = k; vb_ly = int'(ly); end
            if (frame_start) begin fs_cnt++; fs_k = k; end
            if (stat_irq && (ly == 8'd9 || ly == 8'd10)) irq_win++;
        end
        chk("drawline_first", dl_first, 80);
        chk("drawline_gap_bad", dl_gap_bad, 0);
        chk("drawline_count", dl_cnt, 144);
        chk("vblank_count", vb_cnt, 1);
        chk("vblank_time", vb_k, 65664);
        chk("vblank_ly", vb_ly, 144);
        chk("frame_start_count", fs_cnt, 1);
        chk("frame_period", fs_k, 70224);
        chk("stat_blocking_irqs", irq_win, 1);

        // LYC interrupt.
        #1 lyc = 8'd5; stat_ie = 4'b1000;
        found = 0;
        for (int k = 0; k < 3000 && found == 0; k++) begin
            @(negedge clk);
            if (coincidence) found = 1;
        end
        chk("lyc_found", found, 1);
        chk("lyc_ly", int'(ly), 5);
        chk("lyc_dot_x", int'(dot_x), 0);
        @(negedge clk);
        chk("lyc_stat_irq", int'(stat_irq), 1);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (stat_irq) cnt++;
        end
        chk("lyc_single_irq", cnt, 0);
        #1 lyc = 8'd7;
        @(negedge clk);
        chk("lyc_change_drop", int'(coincidence), 0);

        // Disable mid-line at ly=20, dot_x=100.
        found = 0;
        for (int k = 0; k < 8000 && found == 0; k++) begin
            @(negedge clk);
            if (ly == 8'd20 && dot_x == 9'd100) found = 1;
        end
        chk("disable_point_found", found, 1);
        #1 lcd_enable = 1'b0;
        nz = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if ({ly, dot_x, mode, coincidence, drawline, frame_start, vblank_irq, stat_irq} != '0) nz++;
        end
        chk("disabled_all_zero", nz, 0);
        #1 lcd_enable = 1'b1;
        @(negedge clk);
        chk("reenable_frame_start", int'(frame_start), 1);
        chk("reenable_ly", int'(ly), 0);
        chk("reenable_mode", int'(mode), 2);

        // Throttled dots: dot_en alternates, first dot edge has dot_en=0.
        #1 dot_en = 1'b0;
        dl_first = -1; cnt = 0;
        for (int j = 1; j <= 400; j++) begin
            @(negedge clk);
            if (drawline) begin
                cnt++;
                if (dl_first < 0) dl_first = j;
            end
            #1 dot_en = ~dot_en;
        end
        chk("throttle_drawline_time", dl_first, 160);
        chk("throttle_drawline_count", cnt, 1);

        // Random stimulus against the model.
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            #1;
            dot_en     = ($urandom_range(0, 3) != 0);
            lcd_enable = ($urandom_range(0, 199) != 0);
            reset_n    = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 15) == 0) lyc = 8'($urandom_range(0, 2));
            if ($urandom_range(0, 31) == 0) stat_ie = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
